// File: rtl/fa_bist_pkg.sv
// Shared constants for the full-adder BIST: state codes, vector/signature sizes, signature bit mapping.
// No latency or backpressure of its own; the package holds definitions only.
package fa_bist_pkg;

  localparam int N_VEC = 8;
  localparam int SIG_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SANITY = 3'd1;
  localparam logic [2:0] ST_APPLY  = 3'd2;
  localparam logic [2:0] ST_REPORT = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Sum flag of vector v lands on bit 2v and the Cout flag on bit 2v+1.
  function automatic logic [3:0] sig_bit(input logic [2:0] vec, input logic is_cout);
    return {vec, is_cout};
  endfunction

endpackage

// File: rtl/fa_bist_vec_seq.sv
// Steps the {A,B,Cin} vector 0..7, holding each one for SETTLE_CYCLES cycles and strobing on its last cycle.
// Strobe is combinational from the counters. Dropping en clears both counters on the next edge; there is no backpressure.
module fa_bist_vec_seq
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [2:0] vec,
  output logic       sample_stb,
  output logic       last_vec
);

  localparam int ST_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [ST_W-1:0] settle_cnt;

  assign sample_stb = en && (settle_cnt == ST_W'(SETTLE_CYCLES - 1));
  assign last_vec   = (vec == 3'(N_VEC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= 3'd0;
      settle_cnt <= '0;
    end else if (!en) begin
      vec        <= 3'd0;
      settle_cnt <= '0;
    end else if (sample_stb) begin
      vec        <= vec + 3'd1;
      settle_cnt <= '0;
    end else begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fa_bist_controller.sv
// Sweeps every fault site and stuck value over all 8 vectors and reports one signature per fault; start-to-done takes 1+8*SETTLE*(1+2*N_SITES)+2*N_SITES cycles.
// There is no backpressure: sig_valid is a one-cycle strobe, start is ignored while busy, and abort wins over start.
module fa_bist_controller
  import fa_bist_pkg::*;
#(
  parameter int N_SITES       = 4,
  parameter int SITE_W        = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              fault_sum,
  input  logic              fault_cout,
  output logic              A,
  output logic              B,
  output logic              Cin,
  output logic              fault_enable,
  output logic [SITE_W-1:0] fault_site,
  output logic              stuck_val,
  output logic              busy,
  output logic              done,
  output logic              sanity_err,
  output logic              sig_valid,
  output logic [SITE_W-1:0] sig_site,
  output logic              sig_stuck,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  detected_cnt,
  output logic [CNT_W-1:0]  undet_cnt
);

  logic [2:0]        state;
  logic [SITE_W-1:0] site_q;
  logic              stuck_q;
  logic [SIG_W-1:0]  sig_q;
  logic [CNT_W-1:0]  det_q;
  logic [CNT_W-1:0]  undet_q;
  logic              san_err_q;

  logic       seq_en;
  logic [2:0] vec;
  logic       sample_stb;
  logic       last_vec;

  assign seq_en = (state == ST_SANITY) || (state == ST_APPLY);

  // Gating en with abort clears the vector counter on the same edge that aborts.
  fa_bist_vec_seq #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_vec_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (seq_en && !abort),
    .vec        (vec),
    .sample_stb (sample_stb),
    .last_vec   (last_vec)
  );

  assign A            = seq_en & vec[2];
  assign B            = seq_en & vec[1];
  assign Cin          = seq_en & vec[0];
  assign fault_enable = (state == ST_APPLY) || (state == ST_REPORT);
  assign fault_site   = site_q;
  assign stuck_val    = stuck_q;
  assign busy         = fault_enable || (state == ST_SANITY);
  assign done         = (state == ST_DONE);
  assign sanity_err   = san_err_q;
  assign sig_valid    = (state == ST_REPORT);
  assign sig_site     = sig_valid ? site_q : '0;
  assign sig_stuck    = sig_valid & stuck_q;
  assign signature    = sig_q;
  assign detected_cnt = det_q;
  assign undet_cnt    = undet_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      site_q    <= '0;
      stuck_q   <= 1'b0;
      sig_q     <= '0;
      det_q     <= '0;
      undet_q   <= '0;
      san_err_q <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      site_q    <= '0;
      stuck_q   <= 1'b0;
      sig_q     <= '0;
      det_q     <= '0;
      undet_q   <= '0;
      san_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_SANITY;
            site_q    <= '0;
            stuck_q   <= 1'b0;
            sig_q     <= '0;
            det_q     <= '0;
            undet_q   <= '0;
            san_err_q <= 1'b0;
          end
        end
        ST_SANITY: begin
          if (sample_stb) begin
            if (fault_sum || fault_cout) begin
              san_err_q <= 1'b1;
              state     <= ST_DONE;
            end else if (last_vec) begin
              state <= ST_APPLY;
            end
          end
        end
        ST_APPLY: begin
          if (sample_stb) begin
            sig_q <= sig_q | (SIG_W'(fault_sum) << sig_bit(vec, 1'b0))
                           | (SIG_W'(fault_cout) << sig_bit(vec, 1'b1));
            if (last_vec) state <= ST_REPORT;
          end
        end
        ST_REPORT: begin
          if (sig_q != '0) det_q <= det_q + 1'b1;
          else             undet_q <= undet_q + 1'b1;
          // Fault order: stuck-at-0 then stuck-at-1 on each site, sites ascending.
          if (!stuck_q) begin
            stuck_q <= 1'b1;
            sig_q   <= '0;
            state   <= ST_APPLY;
          end else if (site_q == SITE_W'(N_SITES - 1)) begin
            site_q  <= '0;
            stuck_q <= 1'b0;
            state   <= ST_DONE;
          end else begin
            site_q  <= site_q + 1'b1;
            stuck_q <= 1'b0;
            sig_q   <= '0;
            state   <= ST_APPLY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_bist_controller.sv
// Drives the controller with a behavioural good/faulty full-adder pair and scoreboards the reported signatures.
module tb_fa_bist_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        fault_sum, fault_cout;
  logic        A, B, Cin, fault_enable, stuck_val, busy, done, sanity_err, sig_valid, sig_stuck;
  logic [1:0]  fault_site, sig_site;
  logic [15:0] signature;
  logic [3:0]  detected_cnt, undet_cnt;

  fa_bist_controller #(.N_SITES(4), .SITE_W(2), .SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fault_sum(fault_sum), .fault_cout(fault_cout),
    .A(A), .B(B), .Cin(Cin), .fault_enable(fault_enable), .fault_site(fault_site),
    .stuck_val(stuck_val), .busy(busy), .done(done), .sanity_err(sanity_err),
    .sig_valid(sig_valid), .sig_site(sig_site), .sig_stuck(sig_stuck),
    .signature(signature), .detected_cnt(detected_cnt), .undet_cnt(undet_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  site;
    logic        stuck;
    logic [15:0] sig;
  } rep_t;

  rep_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  logic       rich = 1'b0;
  logic       force_san = 1'b0;
  logic [2:0] bad_vec = 3'd0;
  logic [1:0] good_o, bad_o;
  logic       force_hit;
  logic [37:0] out_all;

  // Site 0 is X1; in rich mode sites 1 and 2 are the two AND nodes feeding Cout; site 3 never affects outputs.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c, input logic en,
                                    input logic [1:0] site, input logic stuck, input logic rich_m);
    logic x1, g1, g2;
    x1 = a ^ b;
    if (en && site == 2'd0) x1 = stuck;
    g1 = a & b;
    if (en && rich_m && site == 2'd1) g1 = stuck;
    g2 = x1 & c;
    if (en && rich_m && site == 2'd2) g2 = stuck;
    return {x1 ^ c, g1 | g2};
  endfunction

  assign good_o     = fa(A, B, Cin, 1'b0, 2'd0, 1'b0, rich);
  assign bad_o      = fa(A, B, Cin, fault_enable, fault_site, stuck_val, rich);
  assign force_hit  = force_san && !fault_enable && ({A, B, Cin} == bad_vec);
  assign fault_sum  = (good_o[1] ^ bad_o[1]) | force_hit;
  assign fault_cout = good_o[0] ^ bad_o[0];

  assign out_all = {A, B, Cin, fault_enable, fault_site, stuck_val, busy, done, sanity_err,
                    sig_valid, sig_site, sig_stuck, signature, detected_cnt, undet_cnt};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Builds the ordered list of expected reports for one full sweep.
  task automatic push_table(input logic rich_m, output int det, output int undet);
    logic [15:0] sig;
    logic [1:0]  g, f;
    det = 0;
    undet = 0;
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 2; k++) begin
        if (rich_m) begin
          sig = '0;
          for (int v = 0; v < 8; v++) begin
            g = fa(v[2], v[1], v[0], 1'b0, 2'd0, 1'b0, 1'b1);
            f = fa(v[2], v[1], v[0], 1'b1, 2'(s), 1'(k), 1'b1);
            sig[2*v]   = g[1] ^ f[1];
            sig[2*v+1] = g[0] ^ f[0];
          end
        end else begin
          sig = (s == 0) ? ((k == 1) ? 16'h500D : 16'h0DD0) : 16'h0000;
        end
        exp_q.push_back('{site: 2'(s), stuck: 1'(k), sig: sig});
        if (sig != 0) det++;
        else undet++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && sig_valid) begin
      if (exp_q.size() == 0) begin
        check("sig_unexpected", 64'(sig_valid), 64'd0);
      end else begin
        rep_t e;
        e = exp_q.pop_front();
        check("sig_report", 64'({sig_site, sig_stuck, signature}), 64'(e));
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic sweep(input logic rich_m, input int poke, input logic san_fail, input logic [2:0] bvec);
    int det, undet, cyc, exp_cyc;
    det = 0;
    undet = 0;
    rich = rich_m;
    force_san = san_fail;
    bad_vec = bvec;
    if (!san_fail) push_table(rich_m, det, undet);
    exp_cyc = san_fail ? (2 * int'(bvec) + 3) : 153;
    pulse_start();
    cyc = 1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
    end
    start = 1'b0;
    check("done_latency", 64'(cyc), 64'(exp_cyc));
    check("sanity_err", 64'(sanity_err), 64'(san_fail));
    check("detected_cnt", 64'(detected_cnt), 64'(det));
    check("undet_cnt", 64'(undet_cnt), 64'(undet));
    if (!san_fail) check("cnt_sum", 64'(detected_cnt + undet_cnt), 64'd8);
    check("reports_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("done_hold", 64'({done, busy, fault_enable, A, B, Cin}), 64'b100000);
    force_san = 1'b0;
  endtask

  task automatic abort_test(input logic rich_m, input logic with_start);
    int det, undet, cyc;
    rich = rich_m;
    push_table(rich_m, det, undet);
    pulse_start();
    cyc = 0;
    while (!(fault_enable && fault_site == 2'd2) && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_site2", 64'(fault_site), 64'd2);
    repeat ($urandom_range(0, 12)) @(negedge clk);
    abort = 1'b1;
    start = with_start;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    exp_q.delete();
    check("abort_outputs", 64'(out_all), 64'd0);
    repeat (5) @(negedge clk);
    check("abort_stays_idle", 64'(out_all), 64'd0);
  endtask

  task automatic reset_test(input logic rich_m);
    int det, undet, cyc, seen, k;
    rich = rich_m;
    push_table(rich_m, det, undet);
    k = int'($urandom_range(1, 6));
    pulse_start();
    cyc = 0;
    seen = 0;
    while (seen < k && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (sig_valid) seen++;
    end
    check("reach_report", 64'(seen), 64'(k));
    #1 rst_n = 1'b0;
    #1;
    check("rst_sig_valid", 64'(sig_valid), 64'd0);
    check("rst_outputs", 64'(out_all), 64'd0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #16;
    check("reset_outputs", 64'(out_all), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_no_start", 64'(out_all), 64'd0);

    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    check("start_abort_idle", 64'(out_all), 64'd0);

    sweep(1'b0, 0, 1'b0, 3'd0);
    sweep(1'b0, 0, 1'b1, 3'($urandom_range(0, 7)));
    sweep(1'b0, int'($urandom_range(5, 140)), 1'b0, 3'd0);
    sweep(1'b1, int'($urandom_range(5, 140)), 1'b0, 3'd0);
    abort_test(1'($urandom_range(0, 1)), 1'b0);
    abort_test(1'($urandom_range(0, 1)), 1'b1);
    sweep(1'b0, 0, 1'b0, 3'd0);
    reset_test(1'($urandom_range(0, 1)));
    sweep(1'($urandom_range(0, 1)), 0, 1'b0, 3'd0);
    sweep(1'b1, 0, 1'b1, 3'($urandom_range(0, 7)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
